// File: rtl/tx_sequencer.sv
// Transmit keying sequencer: orders T/R relay, PA bias and RF enable on key and
// unkey so relays never switch hot, with an optional transmit-timeout lockout.
module tx_sequencer #(
    parameter logic [23:0] RELAY_DLY   = 24'd768000,
    parameter logic [23:0] BIAS_DLY    = 24'd76800,
    parameter logic [23:0] TAIL_DLY    = 24'd76800,
    parameter logic [31:0] TIMEOUT_CYC = 32'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ptt_req,
    input  logic       ext_txinhibit,
    input  logic       pa_enable,
    input  logic       tr_disable,
    input  logic       vna,
    output logic       pa_exttr,
    output logic       pa_inttr,
    output logic       pwr_envbias,
    output logic       pwr_envpa,
    output logic       pwr_envop,
    output logic       tx_on,
    output logic       tx_timeout,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        KEY_TR     = 3'd1,
        KEY_BIAS   = 3'd2,
        TX         = 3'd3,
        UNKEY_RF   = 3'd4,
        UNKEY_BIAS = 3'd5,
        LOCKOUT    = 3'd6
    } state_t;

    state_t      state, state_nxt;
    logic [23:0] dly_cnt, dly_load;
    logic [31:0] tx_cnt;
    logic        pa_en_l, tr_dis_l, pa_en_nxt, tr_dis_nxt;
    logic        tmo_nxt, timeout_hit, release_req;
    logic        tr_nxt, bias_nxt;
    logic        exttr_nxt, inttr_nxt, envbias_nxt, envop_nxt, tx_on_nxt;
    logic        envbias_q;

    // A zero delay still costs one cycle in the state.
    function automatic logic [23:0] dly_m1(input logic [23:0] d);
        return (d == 24'd0) ? 24'd0 : d - 24'd1;
    endfunction

    assign release_req = ~ptt_req | ext_txinhibit;
    assign timeout_hit = (TIMEOUT_CYC != 32'd0) && (tx_cnt == TIMEOUT_CYC - 32'd1);

    // State register plus the registered outputs derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dly_cnt     <= 24'd0;
            tx_cnt      <= 32'd0;
            tx_timeout  <= 1'b0;
            pa_en_l     <= 1'b0;
            tr_dis_l    <= 1'b0;
            pa_exttr    <= 1'b0;
            pa_inttr    <= 1'b0;
            envbias_q   <= 1'b0;
            pwr_envop   <= vna & ~ext_txinhibit;
            tx_on       <= 1'b0;
        end else begin
            state      <= state_nxt;
            tx_timeout <= tmo_nxt;
            pa_en_l    <= pa_en_nxt;
            tr_dis_l   <= tr_dis_nxt;
            if (state_nxt != state)
                dly_cnt <= dly_load;
            else if (dly_cnt != 24'd0)
                dly_cnt <= dly_cnt - 24'd1;
            if (state_nxt == TX && state != TX)
                tx_cnt <= 32'd0;
            else if (state == TX && tx_cnt != 32'hFFFF_FFFF)
                tx_cnt <= tx_cnt + 32'd1;
            pa_exttr  <= exttr_nxt;
            pa_inttr  <= inttr_nxt;
            envbias_q <= envbias_nxt;
            pwr_envop <= envop_nxt;
            tx_on     <= tx_on_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        tmo_nxt    = tx_timeout;
        pa_en_nxt  = pa_en_l;
        tr_dis_nxt = tr_dis_l;
        case (state)
            IDLE: begin
                if (ptt_req && !ext_txinhibit && !tx_timeout) begin
                    state_nxt  = KEY_TR;
                    pa_en_nxt  = pa_enable;
                    tr_dis_nxt = tr_disable;
                end
            end
            // No RF has gone out yet, so an early release skips the tail.
            KEY_TR: begin
                if (release_req)              state_nxt = UNKEY_BIAS;
                else if (dly_cnt == 24'd0)    state_nxt = KEY_BIAS;
            end
            KEY_BIAS: begin
                if (release_req)              state_nxt = UNKEY_BIAS;
                else if (dly_cnt == 24'd0)    state_nxt = TX;
            end
            TX: begin
                if (timeout_hit) begin
                    state_nxt = UNKEY_RF;
                    tmo_nxt   = 1'b1;
                end else if (release_req) begin
                    state_nxt = UNKEY_RF;
                end
            end
            UNKEY_RF: begin
                if (dly_cnt == 24'd0) state_nxt = UNKEY_BIAS;
            end
            UNKEY_BIAS: begin
                if (dly_cnt == 24'd0) state_nxt = tx_timeout ? LOCKOUT : IDLE;
            end
            LOCKOUT: begin
                if (!ptt_req) begin
                    state_nxt = IDLE;
                    tmo_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tr_nxt      = state_nxt inside {KEY_TR, KEY_BIAS, TX, UNKEY_RF, UNKEY_BIAS};
        bias_nxt    = state_nxt inside {KEY_BIAS, TX, UNKEY_RF};
        exttr_nxt   = tr_nxt;
        inttr_nxt   = tr_nxt & (pa_en_nxt | ~tr_dis_nxt);
        envbias_nxt = bias_nxt & pa_en_nxt;
        envop_nxt   = bias_nxt | (vna & ~ext_txinhibit);
        tx_on_nxt   = (state_nxt == TX);
        case (state_nxt)
            KEY_TR, UNKEY_BIAS: dly_load = dly_m1(RELAY_DLY);
            KEY_BIAS:           dly_load = dly_m1(BIAS_DLY);
            UNKEY_RF:           dly_load = dly_m1(TAIL_DLY);
            default:            dly_load = 24'd0;
        endcase
    end

    assign pwr_envbias = envbias_q;
    assign pwr_envpa   = envbias_q;
    assign seq_state   = state;

endmodule
